// File: rtl/phase_square_gen_pkg.sv
// Shared constants, FSM state type and phase-word helper for the phase_square_gen block.
// Combinational only; no latency, no flow control.
package phase_pkg;

  localparam int unsigned F_CLK       = 100_000_000;
  localparam logic [31:0] PHASE_SCALE = 32'd11930465;  // round(2^32 / 360)
  localparam logic [15:0] MAX_DEG     = 16'd359;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIV,
    APPLY
  } state_e;

  // Only called on degrees already checked against MAX_DEG, so 9 bits suffice.
  function automatic logic [31:0] deg_to_word(input logic [15:0] deg);
    return {23'd0, deg[8:0]} * PHASE_SCALE;
  endfunction

endpackage

// File: rtl/phase_square_gen_if.sv
// Configuration request channel: valid/ready accept of frequency and phase, plus reject pulse.
// Master holds cfg_valid until it sees cfg_ready; data need only be valid in the accept cycle.
interface phase_square_gen_if;

  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] f_signal;
  logic [15:0] phase_deg;
  logic        cfg_err;

  modport master (
    output cfg_valid,
    output f_signal,
    output phase_deg,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  f_signal,
    input  phase_deg,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/phase_square_gen_tw_divider.sv
// Restoring divider: floor((i_num_hi << 32) / DIVISOR), one quotient bit per cycle, 64 cycles.
// o_last flags the final iteration; o_quot holds the result from the following cycle; i_start restarts.
module tw_divider
  import phase_pkg::*;
#(
  parameter int unsigned DIVISOR = F_CLK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_num_hi,
  output logic        o_last,
  output logic [31:0] o_quot
);

  localparam logic [32:0] W_DIV = 33'(DIVISOR);

  logic [31:0] r_rem;
  logic [63:0] r_sh;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [5:0]  r_cnt;
  logic        r_busy;

  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_ge;

  assign w_trial = {r_rem, r_sh[63]};
  assign w_diff  = w_trial - W_DIV;
  assign w_ge    = (w_trial >= W_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_sh   <= {i_num_hi, 32'd0};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_diff[31:0] : w_trial[31:0];
      r_sh   <= {r_sh[62:0], w_ge};
      r_cnt  <= r_cnt + 6'd1;
      if (r_cnt == 6'd63) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_last = r_busy && (r_cnt == 6'd63);
  assign o_quot = r_sh[31:0];

endmodule

// File: rtl/phase_square_gen.sv
// Dual square-wave NCO with programmable frequency and phase lag; outputs registered, 1 cycle behind acc.
// Config accept to apply takes 66 cycles (2 when f=0); cfg_ready is low while a request is in flight.
module phase_square_gen
  import phase_pkg::*;
#(
  parameter int unsigned CLK_HZ = F_CLK,
  parameter int          ACC_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  phase_square_gen_if.slave  cfg,
  output logic               square_wave_1,
  output logic               square_wave_2,
  output logic               period_tick
);

  localparam logic [31:0] F_MAX = 32'(CLK_HZ / 2);

  state_e r_state;
  state_e w_state_nxt;

  logic [31:0]      r_f;
  logic [15:0]      r_deg;
  logic [31:0]      r_pw_pend;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_tuning;
  logic [ACC_W-1:0] r_phase_word;

  logic             w_bad;
  logic             w_start;
  logic             w_apply;
  logic             w_div_last;
  logic [31:0]      w_quot;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_lag;

  tw_divider #(
    .DIVISOR (CLK_HZ)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_num_hi (r_f),
    .o_last   (w_div_last),
    .o_quot   (w_quot)
  );

  assign w_bad = (r_deg > MAX_DEG) || (r_f > F_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    cfg.cfg_ready = 1'b0;
    cfg.cfg_err   = 1'b0;
    w_start       = 1'b0;
    w_apply       = 1'b0;
    case (r_state)
      IDLE: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (w_bad) begin
          cfg.cfg_err = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_f == 32'd0) begin
          w_state_nxt = APPLY;
        end else begin
          w_start     = 1'b1;
          w_state_nxt = DIV;
        end
      end
      DIV: begin
        if (w_div_last) begin
          w_state_nxt = APPLY;
        end
      end
      APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sum = {1'b0, r_acc} + {1'b0, r_tuning};
  assign w_lag = r_acc - r_phase_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f           <= '0;
      r_deg         <= '0;
      r_pw_pend     <= '0;
      r_acc         <= '0;
      r_tuning      <= '0;
      r_phase_word  <= '0;
      square_wave_1 <= 1'b0;
      square_wave_2 <= 1'b0;
      period_tick   <= 1'b0;
    end else begin
      if (r_state == IDLE && cfg.cfg_valid) begin
        r_f   <= cfg.f_signal;
        r_deg <= cfg.phase_deg;
      end
      if (r_state == CHECK) begin
        r_pw_pend <= deg_to_word(r_deg);
      end
      // Loading a new setting restarts the waveform from zero and suppresses any wrap tick.
      if (w_apply) begin
        r_acc        <= '0;
        r_tuning     <= (r_f == 32'd0) ? '0 : w_quot;
        r_phase_word <= r_pw_pend;
        period_tick  <= 1'b0;
      end else begin
        r_acc       <= w_sum[ACC_W-1:0];
        period_tick <= w_sum[ACC_W];
      end
      square_wave_1 <= r_acc[ACC_W-1];
      square_wave_2 <= w_lag[ACC_W-1];
    end
  end

endmodule

// File: tb/tb_phase_square_gen.sv
// Bench for phase_square_gen: closed-form waveform model (output after n cycles = ((n-1)*tw mod 2^32) msb)
// driven by directed corner cases and randomized configurations.
module tb_phase_square_gen;

  localparam longint unsigned CLK_HZ = 100_000_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sq1, sq2, tick;

  phase_square_gen_if cfg_if();

  phase_square_gen #(
    .CLK_HZ (100_000_000),
    .ACC_W  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg           (cfg_if),
    .square_wave_1 (sq1),
    .square_wave_2 (sq2),
    .period_tick   (tick)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] cyc         = 0;

  // Running configuration: accumulator cleared at edge m_base, stepping m_tw per cycle.
  logic [63:0] m_tw = 0, m_pw = 0, m_base = 0;
  bit          chk_en = 1'b0;
  bit          p_valid = 1'b0;
  logic [63:0] p_tw = 0, p_pw = 0, p_base = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // {tick, sq2, sq1} observed after the m-th edge following the clearing edge (m >= 1).
  function automatic logic [2:0] ref_out(input logic [63:0] m, input logic [63:0] tw,
                                         input logic [63:0] pw);
    logic [63:0] a, b;
    logic [31:0] a32, d;
    a   = (m - 1) * tw;
    b   = m * tw;
    a32 = a[31:0];
    d   = a32 - pw[31:0];
    return {((b >> 32) != (a >> 32)), d[31], a32[31]};
  endfunction

  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (chk_en) begin
      if (p_valid && cyc == p_base) begin
        chk("tick_at_apply", 64'(tick), 64'd0);
        if (cyc > m_base) begin
          e = ref_out(cyc - m_base, m_tw, m_pw);
          chk("sq1_at_apply", 64'(sq1), 64'(e[0]));
          chk("sq2_at_apply", 64'(sq2), 64'(e[1]));
        end
        m_tw    = p_tw;
        m_pw    = p_pw;
        m_base  = p_base;
        p_valid = 1'b0;
      end else if (cyc > m_base) begin
        e = ref_out(cyc - m_base, m_tw, m_pw);
        chk("sq1", 64'(sq1), 64'(e[0]));
        chk("sq2", 64'(sq2), 64'(e[1]));
        chk("tick", 64'(tick), 64'(e[2]));
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (cfg_if.cfg_ready) return;
      step();
    end
    chk("ready_timeout", 64'(cfg_if.cfg_ready), 64'd1);
  endtask

  task automatic send(input logic [31:0] f, input logic [15:0] deg, output logic [63:0] acc_edge);
    wait_ready();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.f_signal  = f;
    cfg_if.phase_deg = deg;
    step();
    acc_edge         = cyc;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.f_signal  = $urandom;
    cfg_if.phase_deg = 16'($urandom);
    if (deg <= 16'd359 && 64'(f) <= CLK_HZ / 2) begin
      chk("err_low_on_accept", 64'(cfg_if.cfg_err), 64'd0);
      p_valid = 1'b1;
      p_tw    = (64'(f) << 32) / CLK_HZ;
      p_pw    = 64'(deg) * 64'd11930465;
      p_base  = acc_edge + ((f == 32'd0) ? 64'd2 : 64'd66);
    end else begin
      chk("err_pulse", 64'(cfg_if.cfg_err), 64'd1);
      chk("ready_low_in_check", 64'(cfg_if.cfg_ready), 64'd0);
      step();
      chk("err_one_cycle", 64'(cfg_if.cfg_err), 64'd0);
      chk("ready_after_reject", 64'(cfg_if.cfg_ready), 64'd1);
    end
  endtask

  task automatic run_past(input logic [63:0] a, input int n);
    while (cyc < a + 66) step();
    run(n);
  endtask

  initial begin
    logic [63:0] a, r1 [$], r2 [$], tk [$];
    logic        p1, p2;
    longint      per, lag, tper;
    logic [31:0] f;
    logic [15:0] deg;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.f_signal  = '0;
    cfg_if.phase_deg = '0;
    step();
    step();
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
    chk("rst_err", 64'(cfg_if.cfg_err), 64'd0);
    chk("rst_sq1", 64'(sq1), 64'd0);
    chk("rst_sq2", 64'(sq2), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    rst    = 1'b0;
    m_tw   = 0;
    m_pw   = 0;
    m_base = cyc;
    chk_en = 1'b1;
    run(5);

    // Nominal 1 MHz / 90 degrees, plus edge-interval measurements.
    send(32'd1_000_000, 16'd90, a);
    run_past(a, 2);
    p1 = sq1;
    p2 = sq2;
    repeat (300) begin
      step();
      if (sq1 && !p1) r1.push_back(cyc);
      if (sq2 && !p2) r2.push_back(cyc);
      if (tick) tk.push_back(cyc);
      p1 = sq1;
      p2 = sq2;
    end
    per  = (r1.size() >= 2) ? longint'(r1[1] - r1[0]) : -1;
    tper = (tk.size() >= 2) ? longint'(tk[1] - tk[0]) : -1;
    lag  = -1;
    if (r1.size() >= 1) begin
      foreach (r2[i]) if (lag < 0 && r2[i] > r1[0]) lag = longint'(r2[i] - r1[0]);
    end
    chk("period90_100pm1", 64'(per >= 99 && per <= 101), 64'd1);
    chk("tick_period_100pm1", 64'(tper >= 99 && tper <= 101), 64'd1);
    chk("lag90_25pm1", 64'(lag >= 24 && lag <= 26), 64'd1);

    send(32'd1_000_000, 16'd180, a);
    run_past(a, 250);

    // Rejects: the 180-degree waveform must carry on untouched.
    send(32'd60_000_000, 16'd45, a);
    run(120);
    send(32'd1_000_000, 16'd360, a);
    run(120);
    send(32'd50_000_001, 16'd10, a);
    run(20);

    send(32'd0, 16'd0, a);
    run(1000);

    send(32'd50_000_000, 16'd359, a);
    run_past(a, 100);

    // Reset while dividing: the pending setting must never appear.
    send(32'd2_000_000, 16'd45, a);
    while (cyc < a + 29) step();
    rst    = 1'b1;
    chk_en = 1'b0;
    step();
    chk("midreset_sq1", 64'(sq1), 64'd0);
    chk("midreset_sq2", 64'(sq2), 64'd0);
    chk("midreset_ready", 64'(cfg_if.cfg_ready), 64'd1);
    chk("midreset_tick", 64'(tick), 64'd0);
    rst     = 1'b0;
    m_tw    = 0;
    m_pw    = 0;
    m_base  = cyc;
    p_valid = 1'b0;
    chk_en  = 1'b1;
    run(200);

    // Requests held during the computation must be ignored.
    send(32'd3_000_000, 16'd120, a);
    for (int i = 0; i < 40; i++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.f_signal  = $urandom_range(1, 40_000_000);
      cfg_if.phase_deg = 16'($urandom_range(0, 359));
      step();
      chk("busy_ready_low", 64'(cfg_if.cfg_ready), 64'd0);
    end
    cfg_if.cfg_valid = 1'b0;
    run_past(a, 200);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          f   = $urandom_range(50_000_001, 32'hFFFF_FFFF);
          deg = 16'($urandom_range(0, 65535));
        end
        1: begin
          f   = $urandom_range(0, 1_000_000);
          deg = 16'($urandom_range(360, 65535));
        end
        2: begin
          f   = $urandom_range(1, 2_000_000);
          deg = 16'($urandom_range(0, 359));
        end
        default: begin
          f   = $urandom_range(1, 50_000_000);
          deg = 16'($urandom_range(0, 359));
        end
      endcase
      send(f, deg, a);
      run_past(a, 150);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/phase_square_gen.md
# phase_square_gen

Generates two square waves with a programmable common frequency (Hz) and a programmable phase lag (degrees) of the second wave relative to the first. It is the stimulus-side counterpart of the phase-difference measurement path: `square_wave_1` is the reference and `square_wave_2` lags it by `phase_deg`. A 32-bit phase accumulator (NCO) produces both outputs. Frequency-to-tuning-word conversion uses an internal sequential divider, so new settings are accepted through a valid/ready handshake.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency in Hz; sets the divisor for the tuning word.
- `ACC_W`, 32: phase accumulator width; fixed at 32 for this block.
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `cfg_valid`  in  1  configuration request
- `cfg_ready`  out  1  block can accept a configuration
- `f_signal`  in  32  requested frequency in Hz; sampled on accept
- `phase_deg`  in  16  lag of wave 2 behind wave 1, in degrees (0..359); sampled on accept
- `cfg_err`  out  1  one-cycle pulse when a request is rejected
- `square_wave_1`  out  1  reference square wave
- `square_wave_2`  out  1  lagging square wave
- `period_tick`  out  1  one-cycle pulse on each accumulator wrap

## Operation
- **FSM states:** IDLE, CHECK, DIV, APPLY.
- **IDLE:**
  - `cfg_ready` = 1.
  - On `cfg_valid && cfg_ready`, latch `f_signal` and `phase_deg`, then go to CHECK.
- **CHECK:**
  - Reject if `phase_deg` > 359 or `f_signal` > CLK_HZ/2. A rejected request pulses `cfg_err`, returns to IDLE and leaves the running configuration untouched.
  - If `f_signal` == 0, go to APPLY with tuning word 0.
  - Otherwise go to DIV.
- **DIV:**
  - Restoring division, one quotient bit per cycle, 64 cycles.
  - tuning = floor((f_signal << 32) / CLK_HZ), truncated to 32 bits.
  - Phase word = `phase_deg` × 11930465 (round(2^32/360)); 32-bit result, no overflow for inputs ≤ 359. Computed in parallel with the division.
- **APPLY (one cycle):**
  - Load the tuning word and phase word.
  - Clear the accumulator to 0.
  - Return to IDLE.
- **Accumulator:** acc <= acc + tuning every cycle, modulo 2^32. `period_tick` = carry out of this add.
- **Outputs (registered):**
  - `square_wave_1` = acc[31].
  - `square_wave_2` = (acc − phase_word)[31], i.e. the rising edge of wave 2 trails that of wave 1 by phase_deg/360 of a period.
- **Tuning word 0:**
  - Accumulator frozen at 0.
  - `square_wave_1` = 0; `square_wave_2` static at (0 − phase_word)[31].
  - `period_tick` = 0.
- **Handshake rules:**
  - `cfg_valid` while busy is ignored (`cfg_ready` = 0).
  - Inputs need not stay stable after the accept cycle.

## Timing
- **Reset values:** state IDLE, acc 0, tuning 0, phase_word 0, `square_wave_1` 0, `square_wave_2` 0, `cfg_err` 0, `period_tick` 0, `cfg_ready` 1.
- **Reset mid-DIV or mid-APPLY:** abort; all state takes reset values on the next edge. The partial configuration is never applied.
- **Latency, accept edge to APPLY:** CHECK 1 + DIV 64 = 65 cycles. New tuning is active in the accumulator from cycle 66.
- **Reject path:** accept at cycle 0; `cfg_err` high in cycle 1; `cfg_ready` high again in cycle 2.
- **Outputs while computing:** the previous configuration keeps running during CHECK/DIV. The switch at APPLY is phase-discontinuous by design, because the accumulator is cleared.
- **Output lag:** outputs lag the accumulator value by 1 cycle.
- **Edge quantisation:** edge timing is quantised to 1 clk. Measured lag = round(phase_deg × period / 360) ± 1 cycle.
- **Simultaneous APPLY and accumulator wrap:** APPLY wins; no `period_tick` in that cycle.

## Structure
- **Shared package `phase_pkg`:**
  - F_CLK = 100_000_000
  - PHASE_SCALE = 32'd11930465
  - FSM state enum
  - MAX_DEG = 359
- **Sub-module `tw_divider`:**
  - Sequential 64/32 restoring divider.
  - Start/done handshake, synchronous active-high reset, fixed 64-cycle latency.
  - The top level instantiates one.

## Test plan
- **Nominal 90°:** reset, then configure f=1_000_000, phase=90.
  - Tuning word = 42949672.
  - Period 100 ± 1 cycles.
  - `square_wave_2` rises 25 ± 1 cycles after `square_wave_1`.
  - `period_tick` every 100 ± 1 cycles.
- **180°:** f=1_000_000, phase=180. `square_wave_2` == ~`square_wave_1` except within ±1 cycle of edges.
- **Invalid requests:**
  - f=60_000_000 → `cfg_err` pulse at accept+1; outputs keep the prior frequency.
  - phase=360 → same behaviour.
- **Zero frequency:** f=0, phase=0. After APPLY, both outputs 0 and no `period_tick` for 1000 cycles.
- **Reset during DIV:** assert `rst` at accept+30 → outputs 0 and `cfg_ready`=1 the next cycle; tuning stays 0.
- **Back-to-back requests:** hold `cfg_valid` during DIV with different values → ignored. Only the first request is applied, at accept+65.
